// File: rtl/onehot_mux_unit_pkg.sv
// Shared helpers for the one-hot AND-OR multiplexer.
// Lane indexing into packed multi-lane buses lives here so every user slices lanes the same way.
package onehot_mux_unit_pkg;

    // Lowest bit index of lane idx in a packed bus of width-bit lanes.
    function automatic int lane(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/onehot_mux_unit.sv
// One-hot selected AND-OR multiplexer with select-health flags and optional output register.
// With no select bit set the output is zero; multi-hot selects OR the chosen lanes together.
module onehot_mux_unit
    import onehot_mux_unit_pkg::*;
#(
    parameter int N_INPUTS = 2,
    parameter int W_INPUT  = 32,
    parameter int REG_OUT  = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_INPUTS*W_INPUT-1:0]   in,
    input  logic [N_INPUTS-1:0]           sel,
    output logic [W_INPUT-1:0]            out,
    output logic                          sel_none,
    output logic                          sel_multi,
    output logic                          sel_multi_seen
);

    if (N_INPUTS < 1 || W_INPUT < 1) begin : g_param_check
        $error("onehot_mux_unit: N_INPUTS and W_INPUT must both be >= 1");
    end

    logic [W_INPUT-1:0] masked_s [N_INPUTS];
    logic [W_INPUT-1:0] mux_s;
    logic               none_s;
    logic               multi_s;
    logic               seen_r;

    for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_lane
        assign masked_s[gi] = in[lane(gi, W_INPUT) +: W_INPUT] & {W_INPUT{sel[gi]}};
    end

    // OR together all masked lanes; a single AND-OR level with no priority.
    always_comb begin
        mux_s = {W_INPUT{1'b0}};
        for (int i = 0; i < N_INPUTS; i++) begin
            mux_s = mux_s | masked_s[i];
        end
    end

    assign none_s = ~|sel;

    // Clearing the lowest set bit leaves something only when two or more bits are set.
    if (N_INPUTS == 1) begin : g_multi_single
        assign multi_s = 1'b0;
    end else begin : g_multi_many
        assign multi_s = |(sel & (sel - N_INPUTS'(1'b1)));
    end

    // Sticky record of any multi-hot select since reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_r <= 1'b0;
        end else if (multi_s) begin
            seen_r <= 1'b1;
        end else begin
            seen_r <= seen_r;
        end
    end

    assign sel_multi_seen = seen_r;

    if (REG_OUT != 0) begin : g_reg_out
        logic [W_INPUT-1:0] out_r;
        logic               none_r;
        logic               multi_r;

        // Capture data and flags every cycle; reset shows an idle (no select) data phase.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_r   <= {W_INPUT{1'b0}};
                none_r  <= 1'b1;
                multi_r <= 1'b0;
            end else begin
                out_r   <= mux_s;
                none_r  <= none_s;
                multi_r <= multi_s;
            end
        end

        assign out       = out_r;
        assign sel_none  = none_r;
        assign sel_multi = multi_r;
    end else begin : g_comb_out
        assign out       = mux_s;
        assign sel_none  = none_s;
        assign sel_multi = multi_s;
    end

endmodule

// File: tb/tb_onehot_mux_unit.sv
// Directed self-checking bench for onehot_mux_unit across three parameter sets.
module tb_onehot_mux_unit;

    logic clk;
    int   assertions;
    int   failures;

    // Instance A: N=2, W=32, combinational
    logic         rst_n_a;
    logic [63:0]  in_a;
    logic [1:0]   sel_a;
    logic [31:0]  out_a;
    logic         none_a, multi_a, seen_a;

    // Instance B: N=4, W=8, registered
    logic         rst_n_b;
    logic [31:0]  in_b;
    logic [3:0]   sel_b;
    logic [7:0]   out_b;
    logic         none_b, multi_b, seen_b;

    // Instance C: N=1, W=16, combinational
    logic         rst_n_c;
    logic [15:0]  in_c;
    logic [0:0]   sel_c;
    logic [15:0]  out_c;
    logic         none_c, multi_c, seen_c;

    onehot_mux_unit #(.N_INPUTS(2), .W_INPUT(32), .REG_OUT(0)) u_a (
        .clk(clk), .rst_n(rst_n_a), .in(in_a), .sel(sel_a),
        .out(out_a), .sel_none(none_a), .sel_multi(multi_a), .sel_multi_seen(seen_a)
    );

    onehot_mux_unit #(.N_INPUTS(4), .W_INPUT(8), .REG_OUT(1)) u_b (
        .clk(clk), .rst_n(rst_n_b), .in(in_b), .sel(sel_b),
        .out(out_b), .sel_none(none_b), .sel_multi(multi_b), .sel_multi_seen(seen_b)
    );

    onehot_mux_unit #(.N_INPUTS(1), .W_INPUT(16), .REG_OUT(0)) u_c (
        .clk(clk), .rst_n(rst_n_c), .in(in_c), .sel(sel_c),
        .out(out_c), .sel_none(none_c), .sel_multi(multi_c), .sel_multi_seen(seen_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset;
        rst_n_a = 1'b0; rst_n_b = 1'b0; rst_n_c = 1'b0;
        in_a = 64'h0; sel_a = 2'b00;
        in_b = 32'h0; sel_b = 4'b0000;
        in_c = 16'h0; sel_c = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        assertions++;
        if (out_b !== 8'h00) begin
            failures++; $display("FAIL reset_out_b: got %h expected %h", out_b, 8'h00);
        end
        assertions++;
        if (none_b !== 1'b1 || multi_b !== 1'b0) begin
            failures++; $display("FAIL reset_flags_b: got none=%b multi=%b expected none=1 multi=0", none_b, multi_b);
        end
        assertions++;
        if (seen_a !== 1'b0 || seen_b !== 1'b0) begin
            failures++; $display("FAIL reset_seen: got a=%b b=%b expected 0 0", seen_a, seen_b);
        end
        @(negedge clk);
        rst_n_a = 1'b1; rst_n_b = 1'b1; rst_n_c = 1'b1;
    endtask

    task automatic test_select;
        @(negedge clk);
        in_a  = {32'hBBBB_BBBB, 32'hAAAA_AAAA};
        sel_a = 2'b01;
        #1;
        assertions++;
        if (out_a !== 32'hAAAA_AAAA || none_a !== 1'b0 || multi_a !== 1'b0) begin
            failures++; $display("FAIL sel01: got out=%h none=%b multi=%b expected out=AAAAAAAA none=0 multi=0", out_a, none_a, multi_a);
        end
        sel_a = 2'b10;
        #1;
        assertions++;
        if (out_a !== 32'hBBBB_BBBB) begin
            failures++; $display("FAIL sel10: got %h expected %h", out_a, 32'hBBBB_BBBB);
        end
        sel_a = 2'b00;
        #1;
        assertions++;
        if (out_a !== 32'h0000_0000 || none_a !== 1'b1 || multi_a !== 1'b0) begin
            failures++; $display("FAIL sel00: got out=%h none=%b multi=%b expected out=00000000 none=1 multi=0", out_a, none_a, multi_a);
        end
    endtask

    task automatic test_multi_hot;
        @(negedge clk);
        in_a  = {32'h0F0F_0000, 32'h0000_F0F0};
        sel_a = 2'b11;
        #1;
        assertions++;
        if (out_a !== 32'h0F0F_F0F0 || multi_a !== 1'b1 || none_a !== 1'b0) begin
            failures++; $display("FAIL sel11: got out=%h multi=%b none=%b expected out=0F0FF0F0 multi=1 none=0", out_a, multi_a, none_a);
        end
        assertions++;
        if (seen_a !== 1'b0) begin
            failures++; $display("FAIL seen_before_edge: got %b expected 0", seen_a);
        end
        @(posedge clk);
        #1;
        assertions++;
        if (seen_a !== 1'b1) begin
            failures++; $display("FAIL seen_set: got %b expected 1", seen_a);
        end
        sel_a = 2'b01;
        @(posedge clk);
        #1;
        assertions++;
        if (seen_a !== 1'b1 || multi_a !== 1'b0 || out_a !== 32'h0000_F0F0) begin
            failures++; $display("FAIL seen_sticky: got seen=%b multi=%b out=%h expected seen=1 multi=0 out=0000F0F0", seen_a, multi_a, out_a);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] sels [4];
        logic [7:0] exps [4];
        sels[0] = 4'b0001; sels[1] = 4'b0010; sels[2] = 4'b0100; sels[3] = 4'b1000;
        exps[0] = 8'h11;   exps[1] = 8'h22;   exps[2] = 8'h33;   exps[3] = 8'h44;
        @(negedge clk);
        in_b = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 4; i++) begin
            sel_b = sels[i];
            #1;
            // Before the edge the output still holds the previous capture.
            assertions++;
            if (out_b !== ((i == 0) ? 8'h00 : exps[(i == 0) ? 0 : i - 1])) begin
                failures++; $display("FAIL latency_%0d: got %h expected %h", i, out_b, (i == 0) ? 8'h00 : exps[(i == 0) ? 0 : i - 1]);
            end
            @(posedge clk);
            #1;
            assertions++;
            if (out_b !== exps[i] || none_b !== 1'b0 || multi_b !== 1'b0) begin
                failures++; $display("FAIL step_%0d: got out=%h none=%b multi=%b expected out=%h none=0 multi=0", i, out_b, none_b, multi_b, exps[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_registered_flags;
        @(negedge clk);
        sel_b = 4'b1001;
        @(posedge clk);
        #1;
        assertions++;
        if (out_b !== 8'h55 || multi_b !== 1'b1 || seen_b !== 1'b1) begin
            failures++; $display("FAIL reg_multi: got out=%h multi=%b seen=%b expected out=55 multi=1 seen=1", out_b, multi_b, seen_b);
        end
        @(negedge clk);
        sel_b = 4'b0000;
        @(posedge clk);
        #1;
        assertions++;
        if (out_b !== 8'h00 || none_b !== 1'b1 || multi_b !== 1'b0 || seen_b !== 1'b1) begin
            failures++; $display("FAIL reg_none: got out=%h none=%b multi=%b seen=%b expected out=00 none=1 multi=0 seen=1", out_b, none_b, multi_b, seen_b);
        end
        @(negedge clk);
        sel_b = 4'b1000;
        @(posedge clk);
        #1;
        assertions++;
        if (out_b !== 8'h44) begin
            failures++; $display("FAIL reg_reload: got %h expected %h", out_b, 8'h44);
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        #2;
        rst_n_b = 1'b0;
        #1;
        assertions++;
        if (out_b !== 8'h00 || none_b !== 1'b1 || multi_b !== 1'b0 || seen_b !== 1'b0) begin
            failures++; $display("FAIL async_reset: got out=%h none=%b multi=%b seen=%b expected out=00 none=1 multi=0 seen=0", out_b, none_b, multi_b, seen_b);
        end
        @(posedge clk);
        #1;
        assertions++;
        if (out_b !== 8'h00 || none_b !== 1'b1) begin
            failures++; $display("FAIL reset_hold: got out=%h none=%b expected out=00 none=1", out_b, none_b);
        end
        @(negedge clk);
        rst_n_b = 1'b1;
        sel_b   = 4'b0010;
        @(posedge clk);
        #1;
        assertions++;
        if (out_b !== 8'h22 || none_b !== 1'b0) begin
            failures++; $display("FAIL resume: got out=%h none=%b expected out=22 none=0", out_b, none_b);
        end
    endtask

    task automatic test_single_lane;
        @(negedge clk);
        in_c  = 16'hC3C3;
        sel_c = 1'b1;
        #1;
        assertions++;
        if (out_c !== 16'hC3C3 || multi_c !== 1'b0 || none_c !== 1'b0) begin
            failures++; $display("FAIL single_sel1: got out=%h multi=%b none=%b expected out=C3C3 multi=0 none=0", out_c, multi_c, none_c);
        end
        sel_c = 1'b0;
        #1;
        assertions++;
        if (out_c !== 16'h0000 || none_c !== 1'b1) begin
            failures++; $display("FAIL single_sel0: got out=%h none=%b expected out=0000 none=1", out_c, none_c);
        end
        @(posedge clk);
        #1;
        assertions++;
        if (seen_c !== 1'b0) begin
            failures++; $display("FAIL single_seen: got %b expected 0", seen_c);
        end
    endtask

    initial begin
        assertions = 0;
        failures   = 0;
        test_reset();
        test_select();
        test_multi_hot();
        test_back_to_back();
        test_registered_flags();
        test_async_reset();
        test_single_lane();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
